// File: rtl/byte_bus_mem_responder.sv
// Target end of the byte-serial CPU memory bus: collects a 4-byte address/wdata frame LSB first,
// commits writes to a local word RAM and returns read words as 4 serial bytes.
module byte_bus_mem_responder #(
   parameter int unsigned AW   = 6,
   parameter logic [31:0] BASE = 32'h0000_0000,
   parameter logic [7:0]  MISS = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bus_start,
   input  logic       bus_rw,
   input  logic [7:0] bus_addr_in,
   input  logic [7:0] bus_data_in,
   output logic [7:0] bus_data_out,
   output logic       bus_data_oe,
   output logic       busy,
   output logic       miss,
   output logic       err
);

   localparam int unsigned DEPTH = 1 << AW;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  beat_q, beat_d;
   logic        rw_q, rw_d;
   // Only bytes 0..2 are stored; byte 3 is used straight off the bus at the commit edge.
   logic [23:2] addr_q, addr_d;
   logic [23:0] wdata_q, wdata_d;
   logic [23:0] rd_shift_q, rd_shift_d;
   logic [7:0]  dout_q, dout_d;
   logic        oe_q, oe_d;
   logic        miss_q, miss_d;
   logic        err_q, err_d;

   logic [31:2]   word_addr;
   logic          hit;
   logic [AW-1:0] ram_idx;
   logic [31:0]   ram_rdata;
   logic [31:0]   rd_word;
   logic [31:0]   ram_wdata;
   logic          ram_we;
   logic          commit;
   logic [2:0]    cap_en;

   logic [31:0] mem [DEPTH];

   assign word_addr = {bus_addr_in, addr_q};
   assign hit       = (word_addr[31:AW+2] == BASE[31:AW+2]);
   assign ram_idx   = word_addr[AW+1:2];
   assign ram_rdata = mem[ram_idx];
   assign rd_word   = hit ? ram_rdata : {4{MISS}};
   assign ram_wdata = {bus_data_in, wdata_q};
   assign commit    = (state_q == ST_ADDR) && (beat_q == 2'd3);
   assign ram_we    = commit && !rw_q && hit;

   for (genvar gi = 0; gi < 3; gi++) begin : g_cap
      assign cap_en[gi] = (state_q == ST_ADDR) && (beat_q == 2'(gi));
   end

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      rw_d       = rw_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_shift_d = rd_shift_q;
      dout_d     = dout_q;
      oe_d       = oe_q;
      miss_d     = 1'b0;
      // A start strobe inside a running frame is a protocol violation; the frame carries on.
      err_d      = err_q | (bus_start && (state_q != ST_IDLE));

      if (cap_en[0]) begin
         addr_d[7:2]   = bus_addr_in[7:2];
         wdata_d[7:0]  = bus_data_in;
      end
      if (cap_en[1]) begin
         addr_d[15:8]  = bus_addr_in;
         wdata_d[15:8] = bus_data_in;
      end
      if (cap_en[2]) begin
         addr_d[23:16]  = bus_addr_in;
         wdata_d[23:16] = bus_data_in;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus_start) begin
               state_d = ST_ADDR;
               beat_d  = 2'd0;
               rw_d    = bus_rw;
            end
         end
         ST_ADDR: begin
            beat_d = beat_q + 2'd1;
            if (commit) begin
               state_d = ST_DATA;
               beat_d  = 2'd0;
               miss_d  = !hit;
               if (rw_q) begin
                  dout_d     = rd_word[7:0];
                  rd_shift_d = rd_word[31:8];
                  oe_d       = 1'b1;
               end
            end
         end
         ST_DATA: begin
            beat_d = beat_q + 2'd1;
            if (beat_q == 2'd3) begin
               state_d = ST_IDLE;
               beat_d  = 2'd0;
               oe_d    = 1'b0;
               dout_d  = 8'h00;
            end else if (rw_q) begin
               dout_d     = rd_shift_q[7:0];
               rd_shift_d = {8'h00, rd_shift_q[23:8]};
            end
         end
         default: begin
            state_d = ST_IDLE;
            beat_d  = 2'd0;
            oe_d    = 1'b0;
            dout_d  = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         beat_q     <= 2'd0;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_shift_q <= '0;
         dout_q     <= 8'h00;
         oe_q       <= 1'b0;
         miss_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         rw_q       <= rw_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_shift_q <= rd_shift_d;
         dout_q     <= dout_d;
         oe_q       <= oe_d;
         miss_q     <= miss_d;
         err_q      <= err_d;
      end
   end

   // RAM contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[ram_idx] <= ram_wdata;
      end
   end

   assign bus_data_out = dout_q;
   assign bus_data_oe  = oe_q;
   assign busy         = (state_q != ST_IDLE);
   assign miss         = miss_q;
   assign err          = err_q;

endmodule
